// File: rtl/data_bus_arbiter_pkg.sv
// Shared encodings for the data-bus arbiter: FSM states, bus size codes, owner ids,
// and the alignment rule used when picking a winner.
package data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    localparam logic [1:0] BUS_B = 2'b00;
    localparam logic [1:0] BUS_H = 2'b01;
    localparam logic [1:0] BUS_W = 2'b10;

    localparam int CNT_W = 4;

    // Size code 11 is served as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? BUS_W : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic w_mis;
        case (norm_size(size))
            BUS_B:   w_mis = 1'b0;
            BUS_H:   w_mis = addr_lo[0];
            default: w_mis = (addr_lo != 2'b00);
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_pick.sv
// Winner selection between core (M0) and loader (M1): M0 by default, M1 after MAX_WAIT
// consecutive losses; also flags whether the winning access is misaligned.
module data_bus_arbiter_pick
    import data_bus_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_arb_en,
    input  logic       i_m0_req,
    input  logic       i_m1_req,
    input  logic [1:0] i_m0_size,
    input  logic [1:0] i_m0_addr_lo,
    input  logic [1:0] i_m1_size,
    input  logic [1:0] i_m1_addr_lo,
    output logic       o_gnt_vld,
    output owner_t     o_owner,
    output logic       o_misalign
);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_m1_wins;

    assign w_m1_wins  = i_m1_req && (!i_m0_req || (r_starve_cnt >= CNT_W'(MAX_WAIT)));
    assign o_gnt_vld  = i_arb_en && (i_m0_req || i_m1_req);
    assign o_owner    = w_m1_wins ? OWN_M1 : OWN_M0;
    assign o_misalign = w_m1_wins ? is_misaligned(i_m1_size, i_m1_addr_lo)
                                  : is_misaligned(i_m0_size, i_m0_addr_lo);

    // Counts only contested grants that M0 won; saturates rather than wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
        end else if (o_gnt_vld) begin
            if (w_m1_wins) begin
                r_starve_cnt <= '0;
            end else if (i_m1_req && (r_starve_cnt != '1)) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the DataBusControl port between core (M0) and loader (M1); each access runs
// IDLE->ISSUE->WAIT->RESP, done after BUS_LATENCY+1 edges (misaligned: 1 edge, no strobe).
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_LATENCY = 1,
    parameter int MAX_WAIT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [1:0]            m0_size,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_busy,
    output logic                  m0_done,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [1:0]            m1_size,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_done,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_gnt,
    output logic                  bus_wd,
    output logic                  bus_rd,
    output logic [1:0]            bus_size,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_data_in,
    input  logic [DATA_WIDTH-1:0] bus_data_out
);

    localparam logic [CNT_W-1:0] LAT_LOAD = (BUS_LATENCY > 1) ? CNT_W'(BUS_LATENCY - 2) : '0;

    arb_state_t            r_state;
    owner_t                r_owner;
    logic [CNT_W-1:0]      r_lat_cnt;
    logic                  r_bus_wd;
    logic                  r_bus_rd;
    logic [1:0]            r_bus_size;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic                  r_m0_done;
    logic                  r_m0_err;
    logic [DATA_WIDTH-1:0] r_m0_rdata;
    logic                  r_m1_done;
    logic                  r_m1_err;
    logic [DATA_WIDTH-1:0] r_m1_rdata;
    logic                  r_m1_gnt;

    logic                  w_gnt_vld;
    owner_t                w_owner;
    logic                  w_misalign;
    logic                  w_sel_we;
    logic [1:0]            w_sel_size;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_resp_next;

    data_bus_arbiter_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_arb_en     (r_state == ST_IDLE),
        .i_m0_req     (m0_req),
        .i_m1_req     (m1_req),
        .i_m0_size    (m0_size),
        .i_m0_addr_lo (m0_addr[1:0]),
        .i_m1_size    (m1_size),
        .i_m1_addr_lo (m1_addr[1:0]),
        .o_gnt_vld    (w_gnt_vld),
        .o_owner      (w_owner),
        .o_misalign   (w_misalign)
    );

    assign w_sel_we    = (w_owner == OWN_M1) ? m1_we : m0_we;
    assign w_sel_size  = norm_size((w_owner == OWN_M1) ? m1_size : m0_size);
    assign w_sel_addr  = (w_owner == OWN_M1) ? m1_addr : m0_addr;
    assign w_sel_wdata = (w_owner == OWN_M1) ? m1_wdata : m0_wdata;

    assign w_resp_next = ((r_state == ST_ISSUE) && (BUS_LATENCY == 1)) ||
                         ((r_state == ST_WAIT) && (r_lat_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_M0;
            r_lat_cnt   <= '0;
            r_bus_wd    <= 1'b0;
            r_bus_rd    <= 1'b0;
            r_bus_size  <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_m0_done   <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_done   <= 1'b0;
            r_m1_err    <= 1'b0;
            r_m1_rdata  <= '0;
            r_m1_gnt    <= 1'b0;
        end else begin
            r_bus_wd  <= 1'b0;
            r_bus_rd  <= 1'b0;
            r_m0_done <= 1'b0;
            r_m0_err  <= 1'b0;
            r_m1_done <= 1'b0;
            r_m1_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_owner     <= w_owner;
                        r_m1_gnt    <= (w_owner == OWN_M1);
                        r_bus_size  <= w_sel_size;
                        r_bus_addr  <= w_sel_addr;
                        r_bus_wdata <= w_sel_wdata;
                        // Misaligned accesses never touch the bus; they answer with err next cycle.
                        if (w_misalign) begin
                            r_state   <= ST_RESP;
                            r_m0_done <= (w_owner == OWN_M0);
                            r_m0_err  <= (w_owner == OWN_M0);
                            r_m1_done <= (w_owner == OWN_M1);
                            r_m1_err  <= (w_owner == OWN_M1);
                        end else begin
                            r_state  <= ST_ISSUE;
                            r_bus_wd <= w_sel_we;
                            r_bus_rd <= !w_sel_we;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!w_resp_next) begin
                        r_state   <= ST_WAIT;
                        r_lat_cnt <= LAT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (!w_resp_next) begin
                        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state  <= ST_IDLE;
                    r_m1_gnt <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Read data is sampled on the edge that enters RESP so it is valid alongside done.
            if (w_resp_next) begin
                r_state <= ST_RESP;
                if (r_owner == OWN_M0) begin
                    r_m0_done  <= 1'b1;
                    r_m0_rdata <= bus_data_out;
                end else begin
                    r_m1_done  <= 1'b1;
                    r_m1_rdata <= bus_data_out;
                end
            end
        end
    end

    assign m0_busy     = m0_req && !r_m0_done;
    assign m0_done     = r_m0_done;
    assign m0_err      = r_m0_err;
    assign m0_rdata    = r_m0_rdata;
    assign m1_done     = r_m1_done;
    assign m1_err      = r_m1_err;
    assign m1_rdata    = r_m1_rdata;
    assign m1_gnt      = r_m1_gnt;
    assign bus_wd      = r_bus_wd;
    assign bus_rd      = r_bus_rd;
    assign bus_size    = r_bus_size;
    assign bus_addr    = r_bus_addr;
    assign bus_data_in = r_bus_wdata;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: instance 0 at BUS_LATENCY=1, instance 1 at BUS_LATENCY=3,
// each checked every cycle against a transaction-timeline model plus directed literals.
module tb_data_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          m0_req [2];
    logic          m0_we  [2];
    logic [1:0]    m0_size[2];
    logic [AW-1:0] m0_addr[2];
    logic [DW-1:0] m0_wdata[2];
    logic          m1_req [2];
    logic          m1_we  [2];
    logic [1:0]    m1_size[2];
    logic [AW-1:0] m1_addr[2];
    logic [DW-1:0] m1_wdata[2];
    logic [DW-1:0] bus_dout[2];

    logic          m0_busy[2];
    logic          m0_done[2];
    logic          m0_err [2];
    logic [DW-1:0] m0_rdata[2];
    logic          m1_done[2];
    logic          m1_err [2];
    logic [DW-1:0] m1_rdata[2];
    logic          m1_gnt [2];
    logic          bus_wd [2];
    logic          bus_rd [2];
    logic [1:0]    bus_size[2];
    logic [AW-1:0] bus_addr[2];
    logic [DW-1:0] bus_data_in[2];

    data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUS_LATENCY(1), .MAX_WAIT(MW)) u_dut0 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_size(m0_size[0]), .m0_addr(m0_addr[0]),
        .m0_wdata(m0_wdata[0]), .m0_busy(m0_busy[0]), .m0_done(m0_done[0]), .m0_err(m0_err[0]),
        .m0_rdata(m0_rdata[0]),
        .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_size(m1_size[0]), .m1_addr(m1_addr[0]),
        .m1_wdata(m1_wdata[0]), .m1_done(m1_done[0]), .m1_err(m1_err[0]), .m1_rdata(m1_rdata[0]),
        .m1_gnt(m1_gnt[0]), .bus_wd(bus_wd[0]), .bus_rd(bus_rd[0]), .bus_size(bus_size[0]),
        .bus_addr(bus_addr[0]), .bus_data_in(bus_data_in[0]), .bus_data_out(bus_dout[0])
    );

    data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUS_LATENCY(3), .MAX_WAIT(MW)) u_dut1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_size(m0_size[1]), .m0_addr(m0_addr[1]),
        .m0_wdata(m0_wdata[1]), .m0_busy(m0_busy[1]), .m0_done(m0_done[1]), .m0_err(m0_err[1]),
        .m0_rdata(m0_rdata[1]),
        .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_size(m1_size[1]), .m1_addr(m1_addr[1]),
        .m1_wdata(m1_wdata[1]), .m1_done(m1_done[1]), .m1_err(m1_err[1]), .m1_rdata(m1_rdata[1]),
        .m1_gnt(m1_gnt[1]), .bus_wd(bus_wd[1]), .bus_rd(bus_rd[1]), .bus_size(bus_size[1]),
        .bus_addr(bus_addr[1]), .bus_data_in(bus_data_in[1]), .bus_data_out(bus_dout[1])
    );

    int n_chk = 0;
    int n_bad = 0;

    // Model: each transaction is a timeline of D edges after the grant edge (age 1 = grant edge).
    bit            md_act  [2];
    int            md_age  [2];
    int            md_d    [2];
    int            md_owner[2];
    bit            md_we   [2];
    bit            md_mis  [2];
    logic [1:0]    md_size [2];
    logic [AW-1:0] md_addr [2];
    logic [DW-1:0] md_wdata[2];
    int            md_starve[2];
    logic [DW-1:0] md_rd0  [2];
    logic [DW-1:0] md_rd1  [2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit mis_f(input logic [1:0] sz, input logic [AW-1:0] a);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic no_done(input string nm);
        n_chk++;
        n_bad++;
        $display("FAIL %s: got no completion within bound, expected a done pulse", nm);
    endtask

    task automatic model_loop();
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < 2; k++) begin
                bit p1;
                if (rst) begin
                    md_act[k] = 0; md_age[k] = 0; md_d[k] = 0; md_owner[k] = 0;
                    md_we[k] = 0; md_mis[k] = 0; md_size[k] = '0; md_addr[k] = '0;
                    md_wdata[k] = '0; md_starve[k] = 0; md_rd0[k] = '0; md_rd1[k] = '0;
                end else if (md_act[k]) begin
                    md_age[k]++;
                    if (md_age[k] == md_d[k] && !md_mis[k]) begin
                        if (md_owner[k] == 0) md_rd0[k] = bus_dout[k];
                        else                  md_rd1[k] = bus_dout[k];
                    end
                    if (md_age[k] > md_d[k]) md_act[k] = 0;
                end else if (m0_req[k] || m1_req[k]) begin
                    p1 = m1_req[k] && (!m0_req[k] || md_starve[k] >= MW);
                    if (p1) begin
                        md_starve[k] = 0;
                        md_owner[k] = 1; md_we[k] = m1_we[k]; md_size[k] = m1_size[k];
                        md_addr[k] = m1_addr[k]; md_wdata[k] = m1_wdata[k];
                    end else begin
                        if (m1_req[k] && md_starve[k] < 15) md_starve[k]++;
                        md_owner[k] = 0; md_we[k] = m0_we[k]; md_size[k] = m0_size[k];
                        md_addr[k] = m0_addr[k]; md_wdata[k] = m0_wdata[k];
                    end
                    md_mis[k] = mis_f(md_size[k], md_addr[k]);
                    md_d[k]   = md_mis[k] ? 1 : lat_of(k) + 1;
                    md_act[k] = 1;
                    md_age[k] = 1;
                end
            end
        end
    endtask

    task automatic cmp_loop();
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bit es, ed0, ed1;
                es  = md_act[k] && md_age[k] == 1 && !md_mis[k];
                ed0 = md_act[k] && md_age[k] == md_d[k] && md_owner[k] == 0;
                ed1 = md_act[k] && md_age[k] == md_d[k] && md_owner[k] == 1;
                check($sformatf("dut%0d.bus_rd", k),   bus_rd[k],  es && !md_we[k]);
                check($sformatf("dut%0d.bus_wd", k),   bus_wd[k],  es && md_we[k]);
                check($sformatf("dut%0d.m0_done", k),  m0_done[k], ed0);
                check($sformatf("dut%0d.m0_err", k),   m0_err[k],  ed0 && md_mis[k]);
                check($sformatf("dut%0d.m1_done", k),  m1_done[k], ed1);
                check($sformatf("dut%0d.m1_err", k),   m1_err[k],  ed1 && md_mis[k]);
                check($sformatf("dut%0d.m1_gnt", k),   m1_gnt[k],  md_act[k] && md_owner[k] == 1);
                check($sformatf("dut%0d.m0_busy", k),  m0_busy[k], m0_req[k] && !ed0);
                check($sformatf("dut%0d.m0_rdata", k), m0_rdata[k], md_rd0[k]);
                check($sformatf("dut%0d.m1_rdata", k), m1_rdata[k], md_rd1[k]);
                if (md_act[k] && !md_mis[k]) begin
                    check($sformatf("dut%0d.bus_addr", k), bus_addr[k],    md_addr[k]);
                    check($sformatf("dut%0d.bus_size", k), bus_size[k],    md_size[k]);
                    check($sformatf("dut%0d.bus_din", k),  bus_data_in[k], md_wdata[k]);
                end
            end
        end
    endtask

    // One access from master mst on instance k; req held until done, dropped right after.
    task automatic access(input int k, input int mst, input logic we, input logic [1:0] sz,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          output int lat, output int strobe_at, output logic err);
        @(posedge clk); #2;
        if (mst == 0) begin
            m0_we[k] = we; m0_size[k] = sz; m0_addr[k] = a; m0_wdata[k] = wd; m0_req[k] = 1'b1;
        end else begin
            m1_we[k] = we; m1_size[k] = sz; m1_addr[k] = a; m1_wdata[k] = wd; m1_req[k] = 1'b1;
        end
        #1;
        if (mst == 0) check($sformatf("dut%0d.busy_on_req", k), m0_busy[k], 1'b1);
        lat = 0; strobe_at = 0; err = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if ((bus_rd[k] || bus_wd[k]) && strobe_at == 0) strobe_at = n;
            if ((mst == 0) ? m0_done[k] : m1_done[k]) begin
                lat = n;
                err = (mst == 0) ? m0_err[k] : m1_err[k];
                break;
            end
        end
        if (lat == 0) no_done($sformatf("dut%0d.access", k));
        #1;
        if (mst == 0) m0_req[k] = 1'b0;
        else          m1_req[k] = 1'b0;
    endtask

    initial begin
        int   lat, sat, c0;
        logic err;
        bit   got;
        for (int k = 0; k < 2; k++) begin
            m0_req[k] = 0; m0_we[k] = 0; m0_size[k] = '0; m0_addr[k] = '0; m0_wdata[k] = '0;
            m1_req[k] = 0; m1_we[k] = 0; m1_size[k] = '0; m1_addr[k] = '0; m1_wdata[k] = '0;
            bus_dout[k] = '0;
        end
        fork
            model_loop();
            cmp_loop();
        join_none
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m0_rdata", m0_rdata[0], '0);
        check("rst_bus_addr", bus_addr[1], '0);
        check("rst_m1_gnt",   m1_gnt[0], 1'b0);
        check("rst_bus_rd",   bus_rd[1], 1'b0);
        #1 rst = 1'b0;

        // Word load, latency 1.
        bus_dout[0] = 32'hDEAD_BEEF;
        access(0, 0, 1'b0, 2'b10, 32'h100, '0, lat, sat, err);
        check("t1_latency", lat, 2);
        check("t1_rd_edge", sat, 1);
        check("t1_rdata",   m0_rdata[0], 32'hDEAD_BEEF);

        // Byte store to an odd address is aligned.
        access(0, 0, 1'b1, 2'b00, 32'h103, 32'h0000_00A5, lat, sat, err);
        check("t2_latency", lat, 2);
        check("t2_wd_edge", sat, 1);
        check("t2_bus_addr", bus_addr[0], 32'h103);
        check("t2_bus_size", bus_size[0], 2'b00);
        check("t2_bus_din",  bus_data_in[0], 32'h0000_00A5);

        // Both masters held: M0 wins MAX_WAIT times, then M1, then M0 again.
        @(posedge clk); #2;
        bus_dout[0] = 32'h1111_2222;
        m0_we[0] = 0; m0_size[0] = 2'b10; m0_addr[0] = 32'h200;
        m1_we[0] = 0; m1_size[0] = 2'b10; m1_addr[0] = 32'h300;
        m0_req[0] = 1'b1; m1_req[0] = 1'b1;
        c0 = 0; got = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clk); #1;
            if (m0_done[0]) c0++;
            if (m1_done[0]) begin
                got = 1;
                check("t3_m1_gnt", m1_gnt[0], 1'b1);
            end
        end
        if (!got) no_done("t3_m1");
        check("t3_m0_wins_first", c0, 4);
        check("t3_m1_rdata", m1_rdata[0], 32'h1111_2222);
        #1 m1_req[0] = 1'b0;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #1;
            if (m0_done[0]) got = 1;
        end
        check("t3_m0_resumes", got, 1'b1);
        check("t3_gnt_back", m1_gnt[0], 1'b0);
        #1 m0_req[0] = 1'b0;

        // Misaligned accesses: no strobe, done+err after one edge, rdata untouched.
        bus_dout[0] = 32'h0000_BEEF;
        access(0, 0, 1'b0, 2'b10, 32'h102, '0, lat, sat, err);
        check("t4_latency", lat, 1);
        check("t4_no_strobe", sat, 0);
        check("t4_err", err, 1'b1);
        check("t4_rdata_kept", m0_rdata[0], 32'h1111_2222);
        access(0, 1, 1'b0, 2'b01, 32'h5, '0, lat, sat, err);
        check("t4_m1_half_err", err, 1'b1);
        access(0, 1, 1'b0, 2'b01, 32'h6, '0, lat, sat, err);
        check("t4_m1_half_lat", lat, 2);
        check("t4_m1_half_ok", err, 1'b0);
        check("t4_m1_rdata", m1_rdata[0], 32'h0000_BEEF);

        // Latency 3 load.
        bus_dout[1] = 32'hCAFE_F00D;
        access(1, 0, 1'b0, 2'b10, 32'h200, '0, lat, sat, err);
        check("t5_latency", lat, 4);
        check("t5_rdata", m0_rdata[1], 32'hCAFE_F00D);

        // Request dropped during WAIT: transaction still completes on time.
        @(posedge clk); #2;
        m0_we[1] = 0; m0_size[1] = 2'b10; m0_addr[1] = 32'h204; m0_req[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m0_req[1] = 1'b0;
        lat = 0;
        for (int n = 3; n <= 40; n++) begin
            @(posedge clk); #1;
            if (m0_done[1]) begin lat = n; break; end
        end
        check("t5_drop_latency", lat, 4);

        // Reset during WAIT discards the access; the held request is served afresh.
        @(posedge clk); #2;
        bus_dout[1] = 32'h0BAD_F00D;
        m0_addr[1] = 32'h208; m0_req[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t6_rst_rd", bus_rd[1], 1'b0);
        check("t6_rst_done", m0_done[1], 1'b0);
        check("t6_rst_rdata", m0_rdata[1], '0);
        @(posedge clk); #2;
        rst = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (m0_done[1]) begin lat = n; break; end
        end
        check("t6_reserve_latency", lat, 4);
        check("t6_rdata", m0_rdata[1], 32'h0BAD_F00D);
        #1 m0_req[1] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
